collatz_orbit_engine: RTL and testbench

- Parametrised successor to the first-generation Collatz/countdown datapath: a full-width Collatz iterator with byte-addressed load/readback.
- From a loaded start value n it runs true Collatz steps (n/2 or 3n+1) to 1, one step per clock.
- Records orbit length (step count) and path record (full-width maximum value reached).
- Flags zero input, arithmetic overflow and orbit-length saturation.
- Sits behind the tile I/O decoder, which maps ui_in/uio_in onto wr_*/rd_*/start and drives uo_out from rd_data.

---
 rtl/collatz_orbit_engine.sv | 115 +++++++++++
 tb/tb_collatz_orbit_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_orbit_engine.sv
// collatz_orbit_engine: full-width Collatz iterator with byte-addressed load and registered readback
module collatz_orbit_engine #(
    parameter int WIDTH  = 32,
    parameter int OLEN_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    input  logic [1:0]        rd_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              err_zero,
    output logic              overflow,
    output logic              timeout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W:0]   IBYTES = (ADDR_W+1)'(WIDTH/8);
    localparam logic [ADDR_W:0]   OBYTES = (ADDR_W+1)'(OLEN_W/8);
    localparam logic [WIDTH-1:0]  ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OLEN_W-1:0] ONE_O  = {{(OLEN_W-1){1'b0}}, 1'b1};
    localparam logic [OLEN_W-1:0] OMAX   = '1;

    state_t            state;
    logic [WIDTH-1:0]  iter, path_rec, step, wr_mask, wr_word;
    logic [OLEN_W-1:0] orbit_len;
    logic [WIDTH+1:0]  ext, nxt;
    logic [7:0]        iter_b, path_b, olen_b, rd_byte;
    logic              ovf, last, wr_ok, rd_ok, ro_ok;

    // next Collatz value at WIDTH+2 bits, byte write masks and readback byte selection
    always_comb begin
        ext     = {2'b00, iter};
        nxt     = iter[0] ? (ext << 1) + ext + {{(WIDTH+1){1'b0}}, 1'b1} : ext >> 1;
        ovf     = |nxt[WIDTH+1:WIDTH];
        step    = nxt[WIDTH-1:0];
        last    = orbit_len == OMAX - ONE_O;
        wr_ok   = {1'b0, wr_addr} < IBYTES;
        wr_mask = {{(WIDTH-8){1'b0}}, 8'hff} << {wr_addr, 3'b000};
        wr_word = {{(WIDTH-8){1'b0}}, wr_data} << {wr_addr, 3'b000};
        rd_ok   = {1'b0, rd_addr} < IBYTES;
        ro_ok   = {1'b0, rd_addr} < OBYTES;
        iter_b  = 8'(iter >> {rd_addr, 3'b000});
        path_b  = 8'(path_rec >> {rd_addr, 3'b000});
        olen_b  = 8'(orbit_len >> {rd_addr, 3'b000});
        rd_byte = rd_sel == 2'd0 ? (rd_ok ? iter_b : 8'h00) :
                  rd_sel == 2'd1 ? (ro_ok ? olen_b : 8'h00) :
                  rd_sel == 2'd2 ? (rd_ok ? path_b : 8'h00) :
                  (rd_addr == '0 ? {4'b0000, timeout, overflow, err_zero, done} : 8'h00);
    end

    // control FSM with iterator, orbit length, path record, flags and registered readback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            iter      <= '0;
            orbit_len <= '0;
            path_rec  <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_zero  <= 1'b0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            rd_data <= rd_byte;
            case (state)
                IDLE, DONE: begin
                    if (wr_en) begin
                        if (wr_ok) iter <= (iter & ~wr_mask) | wr_word;
                        state    <= IDLE;
                        done     <= 1'b0;
                        err_zero <= 1'b0;
                        overflow <= 1'b0;
                        timeout  <= 1'b0;
                    end else if (start) begin
                        orbit_len <= '0;
                        path_rec  <= iter;
                        overflow  <= 1'b0;
                        timeout   <= 1'b0;
                        err_zero  <= iter == '0;
                        done      <= iter == '0 || iter == ONE_W;
                        busy      <= !(iter == '0 || iter == ONE_W);
                        state     <= (iter == '0 || iter == ONE_W) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (ovf) begin
                        overflow <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        iter      <= step;
                        orbit_len <= orbit_len + ONE_O;
                        path_rec  <= step > path_rec ? step : path_rec;
                        if (step == ONE_W || last) begin
                            timeout <= step != ONE_W;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_collatz_orbit_engine.sv
// tb_collatz_orbit_engine: scenario tasks with a readback scoreboard for collatz_orbit_engine
module tb_collatz_orbit_engine;
    localparam int AW = 3;

    logic          clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [1:0]    rd_sel = '0;
    logic [7:0]    rd_data, t8_rd_data;
    logic          busy, done, err_zero, overflow, timeout;
    logic          t8_busy, t8_done, t8_err_zero, t8_overflow, t8_timeout;

    int         checks = 0, errors = 0;
    logic [7:0] sb[$];
    logic [12:0] rq[$];

    collatz_orbit_engine u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err_zero(err_zero), .overflow(overflow), .timeout(timeout)
    );

    collatz_orbit_engine #(.OLEN_W(8)) u_t8 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(t8_rd_data),
        .busy(t8_busy), .done(t8_done), .err_zero(t8_err_zero), .overflow(t8_overflow), .timeout(t8_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] n);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_addr = i[AW-1:0];
            wr_data = n[i*8 +: 8];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic go(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            if (busy) cyc++;
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done: done=%0b after 2000 cycles, required 1", done);
        end
    endtask

    task automatic want_rd(input logic [1:0] s, input int a, input logic [7:0] e);
        rq.push_back({s, a[AW-1:0], e});
    endtask

    task automatic check_reads(input string tag);
        logic [1:0] s;
        logic [AW-1:0] a;
        logic [7:0] e, got;
        while (rq.size() > 0) begin
            {s, a, e} = rq.pop_front();
            rd_sel = s;
            rd_addr = a;
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            checks++;
            if (rd_data !== got) begin
                errors++;
                $display("FAIL %s rd sel=%0d addr=%0d: got %h required %h", tag, s, a, rd_data, got);
            end
        end
    endtask

    task automatic model(input logic [31:0] n0, input int omax, output logic [31:0] it,
                         output int len, output logic [31:0] rec, output logic [7:0] st);
        longint n, nx;
        n = longint'(n0);
        len = 0;
        rec = n0;
        st = 8'h01;
        if (n0 == 0) st = 8'h03;
        else while (n != 1) begin
            nx = n[0] ? 3 * n + 1 : n / 2;
            if (nx > 64'h0000_0000_FFFF_FFFF) begin
                st = 8'h05;
                break;
            end
            n = nx;
            len++;
            if (n > longint'(rec)) rec = n[31:0];
            if (n != 1 && len == omax) begin
                st = 8'h09;
                break;
            end
        end
        it = n[31:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, err_zero, overflow, timeout, rd_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {busy, done, err_zero, overflow, timeout, rd_data});
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            want_rd(2'd0, i, 8'h00);
            want_rd(2'd2, i, 8'h00);
        end
        want_rd(2'd1, 0, 8'h00);
        want_rd(2'd3, 0, 8'h00);
        check_reads("reset");
    endtask

    task automatic test_n6();
        int cyc;
        load(32'd6);
        go(cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL n6_busy: got %0d cycles required 8", cyc);
        end
        want_rd(2'd1, 0, 8'd8);
        want_rd(2'd2, 0, 8'd16);
        want_rd(2'd0, 0, 8'd1);
        want_rd(2'd3, 0, 8'h01);
        check_reads("n6");
    endtask

    task automatic test_back_to_back();
        int cyc;
        go(cyc);
        checks++;
        if (cyc != 0) begin
            errors++;
            $display("FAIL b2b_busy: got %0d cycles required 0", cyc);
        end
        want_rd(2'd1, 0, 8'd0);
        want_rd(2'd2, 0, 8'd1);
        want_rd(2'd3, 0, 8'h01);
        check_reads("b2b");
    endtask

    task automatic test_n27();
        int cyc;
        load(32'd27);
        go(cyc);
        checks++;
        if (cyc != 111) begin
            errors++;
            $display("FAIL n27_busy: got %0d cycles required 111", cyc);
        end
        want_rd(2'd1, 0, 8'h6F);
        want_rd(2'd1, 1, 8'h00);
        want_rd(2'd1, 2, 8'h00);
        want_rd(2'd2, 0, 8'h10);
        want_rd(2'd2, 1, 8'h24);
        want_rd(2'd2, 2, 8'h00);
        want_rd(2'd0, 0, 8'h01);
        want_rd(2'd0, 5, 8'h00);
        want_rd(2'd3, 0, 8'h01);
        check_reads("n27");
        rd_sel = 2'd1;
        rd_addr = '0;
        #1;
        checks++;
        if (rd_data !== 8'h01) begin
            errors++;
            $display("FAIL rd_latency: got %h before edge required %h", rd_data, 8'h01);
        end
        tick();
        checks++;
        if (rd_data !== 8'h6F) begin
            errors++;
            $display("FAIL rd_latency_after: got %h required %h", rd_data, 8'h6F);
        end
    endtask

    task automatic test_edges();
        int cyc;
        load(32'd1);
        go(cyc);
        checks++;
        if (cyc != 0) begin
            errors++;
            $display("FAIL n1_busy: got %0d cycles required 0", cyc);
        end
        want_rd(2'd1, 0, 8'd0);
        want_rd(2'd2, 0, 8'd1);
        want_rd(2'd3, 0, 8'h01);
        check_reads("n1");
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 8'h00;
        tick();
        wr_en = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL write_clears_done: got %0b required 0", done);
        end
        load(32'd0);
        go(cyc);
        want_rd(2'd3, 0, 8'h03);
        want_rd(2'd2, 0, 8'h00);
        want_rd(2'd1, 0, 8'h00);
        check_reads("n0");
    endtask

    task automatic test_overflow();
        int cyc;
        load(32'hFFFF_FFFF);
        go(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL ovf_busy: got %0d cycles required 1", cyc);
        end
        for (int i = 0; i < 4; i++) want_rd(2'd0, i, 8'hFF);
        want_rd(2'd1, 0, 8'h00);
        want_rd(2'd1, 1, 8'h00);
        want_rd(2'd2, 3, 8'hFF);
        want_rd(2'd3, 0, 8'h05);
        check_reads("ovf");
    endtask

    task automatic test_timeout();
        int cyc, len, len8;
        logic [31:0] it, rec, it8, rec8;
        logic [7:0] st, st8;
        model(32'd77031, 65535, it, len, rec, st);
        model(32'd77031, 255, it8, len8, rec8, st8);
        load(32'd77031);
        go(cyc);
        checks++;
        if (cyc != len) begin
            errors++;
            $display("FAIL long_busy: got %0d cycles required %0d", cyc, len);
        end
        want_rd(2'd1, 0, len[7:0]);
        want_rd(2'd1, 1, len[15:8]);
        for (int i = 0; i < 4; i++) want_rd(2'd2, i, rec[i*8 +: 8]);
        want_rd(2'd3, 0, st);
        check_reads("long");
        checks++;
        if ({t8_timeout, t8_overflow, t8_err_zero, t8_done, t8_busy} !== {st8[3:0] == 4'h9, 4'b0010}) begin
            errors++;
            $display("FAIL t8_flags: got %b required %b", {t8_timeout, t8_overflow, t8_err_zero, t8_done, t8_busy}, {st8[3:0] == 4'h9, 4'b0010});
        end
        rd_sel = 2'd1;
        rd_addr = '0;
        tick();
        checks++;
        if (t8_rd_data !== 8'hFF || len8 != 255) begin
            errors++;
            $display("FAIL t8_olen: got %h required ff", t8_rd_data);
        end
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'd0;
            rd_addr = i[AW-1:0];
            tick();
            checks++;
            if (t8_rd_data !== it8[i*8 +: 8]) begin
                errors++;
                $display("FAIL t8_iter byte %0d: got %h required %h", i, t8_rd_data, it8[i*8 +: 8]);
            end
            rd_sel = 2'd2;
            tick();
            checks++;
            if (t8_rd_data !== rec8[i*8 +: 8]) begin
                errors++;
                $display("FAIL t8_path byte %0d: got %h required %h", i, t8_rd_data, rec8[i*8 +: 8]);
            end
        end
        rd_sel = 2'd3;
        rd_addr = '0;
        tick();
        checks++;
        if (t8_rd_data !== st8) begin
            errors++;
            $display("FAIL t8_status: got %h required %h", t8_rd_data, st8);
        end
    endtask

    task automatic test_run_ignores_and_abort();
        int k;
        load(32'd27);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        wr_en = 1'b1;
        wr_addr = '0;
        wr_data = 8'h05;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        for (k = 0; k < 2000 && !done; k++) tick();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ignore_wait: done=%0b required 1", done);
        end
        want_rd(2'd1, 0, 8'h6F);
        want_rd(2'd2, 0, 8'h10);
        want_rd(2'd2, 1, 8'h24);
        check_reads("ignore");
        load(32'd27);
        rd_sel = 2'd0;
        rd_addr = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: got %0b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err_zero, overflow, timeout, rd_data, t8_busy} !== 14'h0) begin
            errors++;
            $display("FAIL abort_outputs: got %h required 0", {busy, done, err_zero, overflow, timeout, rd_data, t8_busy});
        end
        tick();
        rst_n = 1'b1;
        tick();
        want_rd(2'd0, 0, 8'h00);
        want_rd(2'd1, 0, 8'h00);
        want_rd(2'd2, 0, 8'h00);
        want_rd(2'd3, 0, 8'h00);
        check_reads("abort");
    endtask

    initial begin
        test_reset();
        test_n6();
        test_back_to_back();
        test_n27();
        test_edges();
        test_overflow();
        test_timeout();
        test_run_ignores_and_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
